// File: rtl/simon_pkg.sv
// Shared types and constants for the Simon sequencer: FSM state encoding,
// button index type and LFSR seed/taps.
package simon_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADD,
    SHOW_ON,
    SHOW_OFF,
    PLAYER,
    OVER,
    WIN
  } state_t;

  typedef logic [1:0] btn_t;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/simon_lfsr.sv
// 8-bit Galois LFSR (right-shifting, taps 0xB8) that free-runs every cycle;
// its two low bits pick the next button to append to the sequence.
module simon_lfsr
  import simon_pkg::*;
(
  input  logic clk,
  input  logic reset,
  output btn_t o_rand
);

  logic [7:0] r_q;

  always_ff @(posedge clk) begin
    if (reset) r_q <= LFSR_SEED;
    else       r_q <= {1'b0, r_q[7:1]} ^ (r_q[0] ? LFSR_TAPS : 8'h00);
  end

  assign o_rand = r_q[1:0];

endmodule

// File: rtl/simon_sequencer.sv
// Simon game sequencer: grows a random button sequence, plays it back, then
// checks the player's replay. Define SIMON_SPEEDUP_EN to shorten the lit time
// as the sequence grows.
module simon_sequencer
  import simon_pkg::*;
#(
  parameter int MAX_LEN       = 16,
  parameter int ON_TICKS      = 30,
  parameter int OFF_TICKS     = 15,
  parameter int TIMEOUT_TICKS = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] player_num,
  input  logic       player_pressed,
  output logic       simon_turn,
  output logic [1:0] simon_num,
  output logic       simon_pressed,
  output logic [4:0] level,
  output logic       game_over,
  output logic       win
);

  localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TW = 16;

  state_t        r_state;
  btn_t          r_seq [MAX_LEN];
  logic [5:0]    r_len;
  logic [IW-1:0] r_idx;
  logic [TW-1:0] r_timer;

  btn_t          w_rand;
  logic          w_last;
  logic          w_match;
  logic [IW-1:0] w_idx_nxt;
  logic [TW-1:0] w_on_last;

  simon_lfsr u_lfsr (
    .clk    (clk),
    .reset  (reset),
    .o_rand (w_rand)
  );

  assign w_idx_nxt = r_idx + 1'b1;
  assign w_last    = (6'(r_idx) == r_len - 6'd1);
  assign w_match   = (player_num == r_seq[r_idx]);
  assign level     = r_len[4:0];

`ifdef SIMON_SPEEDUP_EN
  // Lit time shrinks by two ticks per level, floored at six ticks.
  int w_on_calc;
  always_comb begin
    w_on_calc = ON_TICKS - 2 * (int'(r_len) - 1);
    if (w_on_calc < 6) w_on_calc = 6;
  end
  assign w_on_last = TW'(w_on_calc - 1);
`else
  assign w_on_last = TW'(ON_TICKS - 1);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_len         <= 6'd0;
      r_idx         <= '0;
      r_timer       <= '0;
      simon_turn    <= 1'b0;
      simon_num     <= 2'd0;
      simon_pressed <= 1'b0;
      game_over     <= 1'b0;
      win           <= 1'b0;
    end else begin
      case (r_state)
        IDLE, OVER, WIN: begin
          if (start) begin
            r_state    <= ADD;
            r_len      <= 6'd0;
            r_idx      <= '0;
            r_timer    <= '0;
            simon_turn <= 1'b1;
            game_over  <= 1'b0;
            win        <= 1'b0;
          end
        end
        ADD: begin
          r_seq[r_len[IW-1:0]] <= w_rand;
          r_len         <= r_len + 6'd1;
          r_idx         <= '0;
          r_timer       <= '0;
          r_state       <= SHOW_ON;
          simon_pressed <= 1'b1;
          // First step of a new game is being written this very cycle.
          simon_num     <= (r_len == 6'd0) ? w_rand : r_seq[0];
        end
        SHOW_ON: begin
          if (r_timer == w_on_last) begin
            r_timer       <= '0;
            r_state       <= SHOW_OFF;
            simon_pressed <= 1'b0;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        SHOW_OFF: begin
          if (r_timer == TW'(OFF_TICKS - 1)) begin
            r_timer <= '0;
            if (!w_last) begin
              r_idx         <= w_idx_nxt;
              r_state       <= SHOW_ON;
              simon_pressed <= 1'b1;
              simon_num     <= r_seq[w_idx_nxt];
            end else begin
              r_idx      <= '0;
              r_state    <= PLAYER;
              simon_turn <= 1'b0;
            end
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        PLAYER: begin
          // A press wins over a timeout landing in the same cycle.
          if (player_pressed) begin
            r_timer <= '0;
            if (!w_match) begin
              r_state   <= OVER;
              game_over <= 1'b1;
            end else if (!w_last) begin
              r_idx <= w_idx_nxt;
            end else if (r_len < 6'(MAX_LEN)) begin
              r_state    <= ADD;
              simon_turn <= 1'b1;
            end else begin
              r_state <= WIN;
              win     <= 1'b1;
            end
          end else if (r_timer == TW'(TIMEOUT_TICKS - 1)) begin
            r_state   <= OVER;
            game_over <= 1'b1;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_simon_sequencer.sv
// Self-checking bench for simon_sequencer: timing table for the player phase,
// plus full-game, wrong-press, ignored-input and reset sequences.
module tb_simon_sequencer;

  localparam int ML  = 16;
  localparam int ON  = 30;
  localparam int OFF = 15;
  localparam int TO  = 120;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [1:0] player_num = 2'd0;
  logic       player_pressed = 1'b0;
  logic       simon_turn, simon_pressed, game_over, win;
  logic [1:0] simon_num;
  logic [4:0] level;

  int checks = 0;
  int errors = 0;

  logic [7:0] m_lfsr = 8'hA5;
  logic [1:0] exp_seq[$];

  simon_sequencer #(
    .MAX_LEN(ML), .ON_TICKS(ON), .OFF_TICKS(OFF), .TIMEOUT_TICKS(TO)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .player_num(player_num),
    .player_pressed(player_pressed), .simon_turn(simon_turn),
    .simon_num(simon_num), .simon_pressed(simon_pressed), .level(level),
    .game_over(game_over), .win(win)
  );

  always #5 clk = ~clk;

  // Reference random source: the LFSR as described, advanced every edge.
  always @(posedge clk) begin
    if (reset) m_lfsr = 8'hA5;
    else       m_lfsr = {1'b0, m_lfsr[7:1]} ^ (m_lfsr[0] ? 8'hB8 : 8'h00);
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic int on_time(input int L);
`ifdef SIMON_SPEEDUP_EN
    int t;
    t = ON - 2 * (L - 1);
    return (t < 6) ? 6 : t;
`else
    return ON;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; player_pressed = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic start_game();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    exp_seq.delete();
  endtask

  task automatic press(input logic [1:0] v);
    player_num = v; player_pressed = 1'b1;
    @(negedge clk);
    player_pressed = 1'b0;
  endtask

  // Entered at the ADD cycle; leaves at the first PLAYER cycle.
  task automatic run_show(input int L, input bit inject);
    int n;
    bit ok;
    chk("add_turn", simon_turn, 1);
    chk("add_level", level, L - 1);
    exp_seq.push_back(m_lfsr[1:0]);
    @(negedge clk);
    for (int i = 0; i < L; i++) begin
      n = 0; ok = 1'b1;
      while (simon_pressed === 1'b1 && n < 100) begin
        if (simon_num !== exp_seq[i] || level !== 5'(L) || simon_turn !== 1'b1) ok = 1'b0;
        player_num     = ~exp_seq[i];
        player_pressed = inject && (n == 3);
        start          = inject && (n == 5);
        n++;
        @(negedge clk);
      end
      player_pressed = 1'b0; start = 1'b0;
      chk("on_cycles", n, on_time(L));
      chk("on_num", ok, 1);
      n = 0; ok = 1'b1;
      while (simon_turn === 1'b1 && simon_pressed === 1'b0 && n < 100) begin
        if (simon_num !== exp_seq[i]) ok = 1'b0;
        n++;
        @(negedge clk);
      end
      chk("off_cycles", n, OFF);
      chk("off_hold", ok, 1);
    end
    chk("player_turn", simon_turn, 0);
  endtask

  task automatic play_level(input int L);
    for (int i = 0; i < L; i++) begin
      repeat ($urandom_range(0, 8)) @(negedge clk);
      press(exp_seq[i]);
      chk("press_no_over", game_over, 0);
    end
  endtask

  typedef struct {
    int press_at;  // PLAYER cycle of the press, 0 = never press
    bit wrong;
    bit exp_over;
    bit exp_turn;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int n;
    vecs[0] = '{1,   1'b0, 1'b0, 1'b1};
    vecs[1] = '{119, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{120, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{121, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{7,   1'b1, 1'b1, 1'b0};
    vecs[5] = '{0,   1'b0, 1'b1, 1'b0};

    @(negedge clk);
    do_reset();
    chk("rst_turn", simon_turn, 0);
    chk("rst_num", simon_num, 0);
    chk("rst_pressed", simon_pressed, 0);
    chk("rst_level", level, 0);
    chk("rst_over", game_over, 0);
    chk("rst_win", win, 0);

    // Player-phase timing table at level 1.
    foreach (vecs[v]) begin
      do_reset();
      start_game();
      run_show(1, 1'b0);
      if (vecs[v].press_at == 0) begin
        n = 0;
        while (game_over !== 1'b1 && n < 300) begin n++; @(negedge clk); end
        chk("timeout_cycles", n, TO);
      end else begin
        repeat (vecs[v].press_at - 1) @(negedge clk);
        press(vecs[v].wrong ? exp_seq[0] ^ 2'b01 : exp_seq[0]);
      end
      chk("tbl_over", game_over, vecs[v].exp_over);
      chk("tbl_turn", simon_turn, vecs[v].exp_turn);
      chk("tbl_level", level, 1);
    end

    // Full game to a win; level 2 also gets a stray press and start mid-show.
    do_reset();
    start_game();
    run_show(1, 1'b0);
    for (int L = 1; L <= ML; L++) begin
      play_level(L);
      if (L < ML) run_show(L + 1, L == 1);
    end
    chk("win_flag", win, 1);
    chk("win_over", game_over, 0);
    chk("win_level", level, ML);
    chk("win_turn", simon_turn, 0);
    repeat (4) @(negedge clk);
    chk("win_hold_level", level, ML);
    start_game();
    chk("restart_win", win, 0);
    chk("restart_turn", simon_turn, 1);

    // Wrong second press at level 3.
    do_reset();
    start_game();
    run_show(1, 1'b0);
    play_level(1);
    run_show(2, 1'b0);
    play_level(2);
    run_show(3, 1'b0);
    press(exp_seq[0]);
    chk("l3_first_ok", game_over, 0);
    press(exp_seq[1] ^ 2'b11);
    chk("l3_over", game_over, 1);
    chk("l3_level", level, 3);
    press(exp_seq[2]);
    chk("l3_over_ignored_press", game_over, 1);
    start_game();
    chk("restart_over", game_over, 0);
    chk("restart_add_level", level, 0);
    @(negedge clk);
    chk("restart_level", level, 1);

    // Reset in the middle of playback abandons the game.
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_turn", simon_turn, 0);
    chk("midrst_pressed", simon_pressed, 0);
    chk("midrst_level", level, 0);
    repeat (5) @(negedge clk);
    chk("midrst_idle", simon_turn, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/simon_sequencer.md
SIMON_SEQUENCER -- requirements
Module: simon_sequencer

Interface
REQ-001 SHALL have parameter MAX_LEN, default 16, maximum sequence length (2..32).
REQ-002 SHALL have parameter ON_TICKS, default 30, clk cycles a shown step is lit.
REQ-003 SHALL have parameter OFF_TICKS, default 15, clk cycles of dark gap after each shown step.
REQ-004 SHALL have parameter TIMEOUT_TICKS, default 120, idle clk cycles allowed between player presses.
REQ-005 SHALL have port clk  input  1  single clock (60 Hz game tick); one clock; all logic on rising edge.
REQ-006 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-007 SHALL have port start  input  1  one-cycle pulse; begins a new game.
REQ-008 SHALL have port player_num  input  2  button index pressed by player.
REQ-009 SHALL have port player_pressed  input  1  one-cycle pulse; player_num valid this cycle.
REQ-010 SHALL have port simon_turn  output  1  high while sequence is being shown.
REQ-011 SHALL have port simon_num  output  2  index of the step being shown.
REQ-012 SHALL have port simon_pressed  output  1  high while the shown step is lit.
REQ-013 SHALL have port level  output  5  current sequence length.
REQ-014 SHALL have port game_over  output  1  high in OVER state.
REQ-015 SHALL have port win  output  1  high in WIN state.

Function
REQ-016 SHALL implement states IDLE, ADD, SHOW_ON, SHOW_OFF, PLAYER, OVER, WIN.
REQ-017 SHALL store the sequence in a MAX_LEN x 2-bit register array written only in ADD.
REQ-018 IDLE/OVER/WIN + start SHALL go to ADD next cycle with len cleared to 0.
REQ-019 ADD SHALL write lfsr[1:0] to seq[len], increment len, clear idx, go to SHOW_ON; ADD lasts exactly one cycle.
REQ-020 SHOW_ON SHALL drive simon_pressed=1, simon_num=seq[idx] for exactly the on-time, then go to SHOW_OFF.
REQ-021 SHOW_OFF SHALL drive simon_pressed=0 for OFF_TICKS cycles, then: idx<len-1 -> idx++, SHOW_ON; else idx=0, timer=0, PLAYER.
REQ-022 simon_turn SHALL be 1 exactly in ADD, SHOW_ON, SHOW_OFF; simon_num SHALL hold its last value outside SHOW_ON.
REQ-023 PLAYER with player_pressed and player_num==seq[idx]: timer=0; idx<len-1 -> idx++; idx==len-1 -> ADD if len<MAX_LEN, else WIN.
REQ-024 PLAYER with player_pressed and mismatch SHALL go to OVER next cycle.
REQ-025 PLAYER without press SHALL increment timer; timer reaching TIMEOUT_TICKS-1 SHALL go to OVER.
REQ-026 player_pressed outside PLAYER SHALL be ignored; start in ADD/SHOW_*/PLAYER SHALL be ignored.
REQ-027 player_pressed and timeout in the same cycle: the press SHALL take priority.
REQ-028 level SHALL equal len; held in OVER/WIN until next start.

Reset
REQ-029 On reset: state=IDLE, len=0, idx=0, timers=0, simon_turn=0, simon_num=0, simon_pressed=0, game_over=0, win=0.
REQ-030 Reset mid-game SHALL abandon the game; seq contents need not be cleared.
REQ-031 LFSR SHALL reload seed 8'hA5 on reset and free-run every cycle otherwise.

Configuration
REQ-032 Macro SIMON_SPEEDUP_EN defined: on-time = max(ON_TICKS - 2*(len-1), 6) cycles.
REQ-033 Macro SIMON_SPEEDUP_EN undefined: on-time = ON_TICKS at every level; no speedup logic.

Structure
REQ-034 Package simon_pkg SHALL hold the state enum typedef, the 2-bit button typedef and the LFSR seed constant.
REQ-035 Sub-module simon_lfsr (8-bit Galois LFSR, taps 0xB8, sync reset to seed) SHALL supply the random value.

Verification
REQ-036 reset 3 cycles, then start -> 1 cycle ADD; level=1, simon_turn=1, simon_pressed=1 for exactly 30 cycles, 0 for 15, then simon_turn=0.
REQ-037 Bench captures shown steps, replays them correctly for levels 1..16 -> win=1 after 16th level, game_over=0.
REQ-038 Level 3, second press wrong -> game_over=1 next cycle, level stays 3; start -> level=1, game_over=0.
REQ-039 PLAYER, no press for 120 cycles -> game_over=1 on cycle 120; press on cycle 119 correct -> no game over.
REQ-040 player_pressed pulsed during SHOW_ON at level 2 -> ignored, playback and idx unchanged.
REQ-041 SIMON_SPEEDUP_EN defined, level 5 -> on-time 22 cycles; level 16 -> 6 cycles; undefined -> 30 at both.
